// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, constants and helpers for the demux round-robin scheduler
package demux_pkg;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [N-1:0] onehot8(input logic [SEL_W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - round-robin pick: first eligible index at or above ptr, wrapping 7 -> 0
module rr_pick8
    import demux_pkg::*;
(
    input  logic [N-1:0]     elig,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;

    // Rotating right by ptr puts the highest-priority candidate at bit 0.
    assign rot = N'({elig, elig} >> ptr);

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign found = |rot;
    assign idx   = off + ptr;

endmodule

// File: rtl/demux_rr_scheduler.sv
// rtl/demux_rr_scheduler.sv - round-robin scheduler driving a 1-to-8 demux with hold limit and dead time
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int GAP      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     cfg_mask,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [N-1:0]     gnt,
    output logic             busy
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [3:0] GAP_C      = 4'(GAP);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q, en_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       gap_q, gap_d;

    logic [N-1:0]     elig;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    assign elig = req & cfg_mask;

    rr_pick8 u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gap_d   = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot8(pick_idx);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    hold_d  = 8'd1;
                end
            end
            ST_GRANT: begin
                // Request drop and hold expiry on the same edge are one release.
                if (!elig[sel_q] || (hold_q >= MAX_HOLD_C)) begin
                    gnt_d  = '0;
                    en_d   = 1'b0;
                    ptr_d  = sel_q + SEL_W'(1);
                    hold_d = '0;
                    if (GAP_C != 4'd0) begin
                        state_d = ST_GAP;
                        gap_d   = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_C) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                en_d    = 1'b0;
                gnt_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb/tb_demux_rr_scheduler.sv - scoreboard bench for demux_rr_scheduler against a grant-level model
module tb_demux_rr_scheduler;

    localparam int MAX_HOLD = 16;
    localparam int GAP      = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] cfg_mask;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;

    demux_rr_scheduler #(.MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .cfg_mask (cfg_mask),
        .sel      (sel),
        .en       (en),
        .gnt      (gnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       busy;
        logic [7:0] gnt;
        logic [2:0] sel;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model: phase 0 idle, 1 granted, 2 dead time.
    int m_phase, m_ch, m_len, m_gap, m_ptr, m_sel;

    task automatic model_reset();
        m_phase = 0; m_ch = 0; m_len = 0; m_gap = 0; m_ptr = 0; m_sel = 0;
    endtask

    task automatic model_step();
        logic [7:0] e;
        exp_t       x;
        bit         f;
        e = req & cfg_mask;
        if (m_phase == 0) begin
            f = 0;
            for (int k = 0; k < 8; k++) begin
                if (!f && e[(m_ptr + k) % 8]) begin
                    f = 1;
                    m_ch = (m_ptr + k) % 8;
                end
            end
            if (f) begin
                m_phase = 1; m_len = 1; m_sel = m_ch;
            end
        end else if (m_phase == 1) begin
            if (!e[m_ch] || m_len == MAX_HOLD) begin
                m_ptr = (m_ch + 1) % 8;
                if (GAP > 0) begin
                    m_phase = 2; m_gap = GAP;
                end else begin
                    m_phase = 0;
                end
            end else begin
                m_len = m_len + 1;
            end
        end else begin
            m_gap = m_gap - 1;
            if (m_gap == 0) m_phase = 0;
        end
        x.en   = (m_phase == 1);
        x.busy = (m_phase != 0);
        x.gnt  = (m_phase == 1) ? (8'd1 << m_ch) : 8'd0;
        x.sel  = 3'(m_sel);
        expq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            req = r;
            cfg_mask = m;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard underflow at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    if ({en, busy, gnt, sel} !== {e.en, e.busy, e.gnt, e.sel}) begin
                        n_bad++;
                        $display("FAIL cycle@%0t: got en=%b busy=%b gnt=%h sel=%0d, expected en=%b busy=%b gnt=%h sel=%0d",
                                 $time, en, busy, gnt, sel, e.en, e.busy, e.gnt, e.sel);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic [7:0] m;
        rst_n = 1'b0;
        req = 8'h00;
        cfg_mask = 8'hFF;
        model_reset();
        #3;
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset in the middle of a grant to channel 3.
        drive(8'h08, 8'hFF, 4);
        req = 8'h08;
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        expq.delete();
        #1;
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        drive(8'h01, 8'hFF, 4);
        drive(8'h00, 8'hFF, 4);

        // Single request, 5 cycles long.
        drive(8'h08, 8'hFF, 5);
        drive(8'h00, 8'hFF, 6);

        // Full contention across a complete rotation.
        drive(8'hFF, 8'hFF, 9 * 18 + 2);
        drive(8'h00, 8'hFF, 4);

        // Pointer order after channel 2.
        drive(8'h04, 8'hFF, 3);
        drive(8'h00, 8'hFF, 3);
        drive(8'h24, 8'hFF, 40);
        drive(8'h00, 8'hFF, 4);

        // Mask blocks, then enables, then cuts a live grant.
        drive(8'h0F, 8'hF0, 5);
        drive(8'h0F, 8'hFF, 3);
        drive(8'h0F, 8'hFE, 3);
        drive(8'h00, 8'hFF, 4);

        // Long request forced off by the hold limit.
        drive(8'h80, 8'hFF, 40);
        drive(8'h00, 8'hFF, 4);

        // Random level-style requests and occasional mask changes.
        r = 8'($urandom);
        m = 8'hFF;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int j;
                j = $urandom_range(0, 7);
                r[j] = ~r[j];
            end
            if ($urandom_range(0, 40) == 0) begin
                m = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            end
            drive(r, m, 1);
        end
        drive(8'h00, 8'hFF, 4);

        @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 1-to-8 demultiplexer between 8 requesting channels.
- Arbitrates the request lines and drives the demux select (s) and data/enable (i) inputs.
- Returns a one-hot grant to the winner, enforces a maximum hold time per grant and inserts a dead-time gap between grants (break-before-make on the demux outputs).
- Sits directly in front of the demux: its sel and en outputs connect to the demux s and i ports.

Parameters:
- N, 8, number of requesters and demux outputs (fixed at 8 for this demux).
- SEL_W, 3, select width, equal to clog2(N).
- MAX_HOLD, 16, maximum consecutive cycles one grant may last (range 1..255).
- GAP, 1, dead cycles after each release before a new grant (range 0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  per-channel request; level-sensitive, held high while the channel wants the demux.
- cfg_mask  input  8  per-channel enable; a 0 bit makes that channel ineligible.
- sel  output  3  demux select, drives s.
- en  output  1  demux input, drives i; high only while a grant is active.
- gnt  output  8  one-hot grant, all zero when idle.
- busy  output  1  high in the GRANT and GAP states.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, sel=0, en=0, gnt=0, busy=0, priority pointer ptr=0, hold_cnt=0, gap_cnt=0.
- All outputs are registered. Reset asserted mid-grant drops en and gnt immediately, without waiting for a clock edge.
- Eligibility: elig = req & cfg_mask.
- The winner is the first elig index at or above ptr, searching upward and wrapping 7 -> 0.
- IDLE:
  - If elig != 0 at a rising edge, register idx into sel, set gnt = 1<<idx, en=1, busy=1, hold_cnt=1, and go to GRANT.
  - Latency is one cycle from req to gnt/en. If elig == 0, remain in IDLE.
- GRANT:
  - sel, gnt and en stay stable. hold_cnt increments each cycle.
  - Release occurs when elig[idx]=0 (req dropped or mask cleared), or when hold_cnt == MAX_HOLD. Simultaneous events count as a single release.
  - On release: gnt=0, en=0, ptr=(idx+1) mod 8, sel holds its last value.
  - After release, go to GAP if GAP>0, otherwise go to IDLE.
  - en is high for exactly min(request duration, MAX_HOLD) cycles.
- GAP:
  - Count GAP cycles with busy=1, en=0 and gnt=0; requests are ignored. Then go to IDLE.
- Minimum spacing between grants is GAP+1 cycles. IDLE always takes one evaluation cycle.
- Requests from other channels arriving during GRANT never preempt the current grant.
- hold_cnt is 8 bits and saturates at MAX_HOLD. gap_cnt is 4 bits.
- No X on outputs after reset under any req or cfg_mask pattern.

Decomposition:
- Shared package demux_pkg holds:
  - the state enum (IDLE, GRANT, GAP);
  - constants N=8 and SEL_W=3;
  - a onehot8 function (3-bit index to 8-bit one-hot).
- One natural combinational sub-module, rr_pick8, takes (elig[7:0], ptr[2:0]) and returns (found, idx[2:0]). It is implemented as a rotate, a priority encode, and an un-rotate.

Test Plan:
1. Reset mid-grant: req=8'h08 granted, then rst_n=0 in the middle of a cycle -> en=0, gnt=0, sel=0 immediately; after release, req=8'h01 -> channel 0 granted (ptr was reset).
2. Single request: req[3] high for 5 cycles (MAX_HOLD=16, GAP=1) -> one cycle later sel=3, gnt=8'h08, en=1 for 5 cycles, then 1 GAP cycle with busy=1, then IDLE.
3. Full contention: req=8'hFF held -> grants in order 0,1,...,7,0; each lasts 16 cycles, separated by 2 cycles with en=0 (GAP plus IDLE).
4. Pointer order: after a grant to channel 2 (ptr=3), req=8'h24 -> channel 5 granted first, then channel 2.
5. Mask: cfg_mask=8'hF0 with req=8'h0F -> no grant, busy=0; then set cfg_mask=8'hFF -> channel 0 granted next cycle. Clearing cfg_mask[0] during that grant -> release on the following edge.
6. Forced release: req[7] held 40 cycles -> en high for exactly 16 cycles, then GAP; with no other requesters, channel 7 is re-granted for the remaining cycles.
